// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared definitions for the rv32i_core CPU tile.
// Contents: opcode and funct3 codes, the control FSM state enum, the ALU
// operation encoding, and helpers that map funct3 fields onto ALU ops.
// No ports; imported by rv32i_alu and rv32i_core.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SW   = 3'b010;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
  } alu_op_t;

  // alt selects SUB/SRA; callers must only raise it where funct7[5] is meaningful
  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t branch_op_from_f3(input logic [2:0] f3);
    case (f3)
      F3_BNE:  return ALU_NE;
      F3_BLT:  return ALU_LT;
      F3_BGE:  return ALU_GE;
      F3_BLTU: return ALU_LTU;
      F3_BGEU: return ALU_GEU;
      default: return ALU_EQ;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// rv32i_alu: combinational ALU for rv32i_core, including branch compares.
// Ports:
//   a, b : 32-bit operands
//   op   : operation (alu_op_t)
//   y    : 32-bit result; compare ops return 0 or 1
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);

  // Shift amounts use only the low five bits of b.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_EQ:   y = {31'b0, a == b};
      ALU_NE:   y = {31'b0, a != b};
      ALU_LT:   y = {31'b0, $signed(a) < $signed(b)};
      ALU_GE:   y = {31'b0, $signed(a) >= $signed(b)};
      ALU_LTU:  y = {31'b0, a < b};
      default:  y = {31'b0, a >= b};
    endcase
  end

endmodule

// File: rtl/rv32i_core.sv
// rv32i_core: minimal multi-cycle RV32I core with one shared memory port.
// FETCH -> EXEC (-> MEM for loads/SW) -> FETCH. RAM read must be combinational.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   mem_addr   : byte address (RAM indexes with mem_addr[31:2])
//   mem_wdata  : store data, zero unless a store is in MEM
//   mem_rdata  : combinational read data for mem_addr
//   mem_we     : word write strobe, high only in MEM of a SW
//   halted     : only with RV32I_ILLEGAL_HALT_EN; high in HALT state
// Optional feature macro: RV32I_ILLEGAL_HALT_EN (unknown opcodes halt the core
// instead of executing as NOP).
module rv32i_core
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we
`ifdef RV32I_ILLEGAL_HALT_EN
  ,
  output logic        halted
`endif
);

  state_t      state, state_next;
  logic [31:0] pc, ir, eff_addr;
  logic [31:0] registers [0:31];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4;

  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op;
  logic [31:0] exec_wdata, exec_pc, load_lane, load_data;
  logic        exec_we, exec_to_mem, illegal;

  assign opcode   = ir[6:0];
  assign rd       = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1      = ir[19:15];
  assign rs2      = ir[24:20];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  // x0 is never written, so a direct read always yields zero for it
  assign rs1_val  = registers[rs1];
  assign rs2_val  = registers[rs2];
  assign pc_plus4 = pc + 32'd4;

  rv32i_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  // Decode: ALU operand selection plus what EXEC commits (rd, next pc, or
  // the hand-off to MEM). Invalid funct3 in loads, SB/SH and invalid branch
  // funct3 fall through as NOPs.
  always_comb begin
    alu_a       = rs1_val;
    alu_b       = imm_i;
    alu_op      = ALU_ADD;
    exec_wdata  = alu_y;
    exec_we     = 1'b0;
    exec_pc     = pc_plus4;
    exec_to_mem = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_b   = rs2_val;
        alu_op  = alu_op_from_f3(funct3, ir[30]);
        exec_we = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_op  = alu_op_from_f3(funct3, (funct3 == F3_SR) && ir[30]);
        exec_we = 1'b1;
      end
      OPC_LUI: begin
        exec_wdata = imm_u;
        exec_we    = 1'b1;
      end
      OPC_AUIPC: begin
        exec_wdata = pc + imm_u;
        exec_we    = 1'b1;
      end
      OPC_JAL: begin
        exec_wdata = pc_plus4;
        exec_we    = 1'b1;
        exec_pc    = pc + imm_j;
      end
      OPC_JALR: begin
        exec_wdata = pc_plus4;
        exec_we    = 1'b1;
        exec_pc    = {alu_y[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        alu_b  = rs2_val;
        alu_op = branch_op_from_f3(funct3);
        if (alu_y[0] && (funct3[2:1] != 2'b01)) exec_pc = pc + imm_b;
      end
      OPC_LOAD:
        exec_to_mem = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      OPC_STORE: begin
        alu_b       = imm_s;
        exec_to_mem = (funct3 == F3_SW);
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: begin
`ifdef RV32I_ILLEGAL_HALT_EN
        illegal = 1'b1;
        exec_pc = pc;
`endif
      end
    endcase
  end

  // Load lane extraction: shift the addressed byte/half down to bit 0.
  always_comb begin
    load_lane = mem_rdata >> {eff_addr[1:0], 3'b000};
    case (funct3)
      F3_LB:   load_data = {{24{load_lane[7]}}, load_lane[7:0]};
      F3_LH:   load_data = {{16{load_lane[15]}}, load_lane[15:0]};
      F3_LBU:  load_data = {24'b0, load_lane[7:0]};
      F3_LHU:  load_data = {16'b0, load_lane[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state and memory port; the port shows pc except during MEM.
  always_comb begin
    state_next = state;
    mem_addr   = pc;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state)
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (illegal)          state_next = S_HALT;
        else if (exec_to_mem) state_next = S_MEM;
        else                  state_next = S_FETCH;
      end
      S_MEM: begin
        mem_addr   = eff_addr;
        state_next = S_FETCH;
        if (opcode == OPC_STORE) begin
          mem_addr  = {eff_addr[31:2], 2'b00};
          mem_wdata = rs2_val;
          mem_we    = 1'b1;
        end
      end
      default: state_next = state;
    endcase
  end

`ifdef RV32I_ILLEGAL_HALT_EN
  assign halted = (state == S_HALT);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Architectural state: only the cycle that completes an instruction
  // touches pc or the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      eff_addr <= '0;
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else begin
      case (state)
        S_FETCH: ir <= mem_rdata;
        S_EXEC: begin
          if (exec_to_mem) begin
            eff_addr <= alu_y;
          end else begin
            pc <= exec_pc;
            if (exec_we && (rd != 5'd0)) registers[rd] <= exec_wdata;
          end
        end
        S_MEM: begin
          pc <= pc_plus4;
          if ((opcode == OPC_LOAD) && (rd != 5'd0)) registers[rd] <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: self-checking bench for rv32i_core. Directed programs from
// the test plan plus randomized ALU/load/store programs compared against an
// instruction-level reference interpreter.
module tb_rv32i_core;

  localparam logic [31:0] LOOP = 32'h0000006f;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
`ifdef RV32I_ILLEGAL_HALT_EN
  logic        halted;
`endif

  logic [31:0] mem   [0:255];
  logic [31:0] img   [0:255];
  logic [31:0] mm    [0:255];
  logic [31:0] mregs [0:31];
  int tests = 0;
  int fails = 0;
  int we_count = 0;
  int we_base;

  rv32i_core #(.RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we)
`ifdef RV32I_ILLEGAL_HALT_EN
    ,
    .halted    (halted)
`endif
  );

  always #5 clk = ~clk;

  // Combinational-read RAM; the image is copied in while load_en is high.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) if (mem_we) we_count <= we_count + 1;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
  endtask

  // Reset with image load; checks reset outputs, then releases on a negedge
  // so that the following sample point is cycle 0 (FETCH at RESET_PC).
  task automatic apply_stimulus();
    @(negedge clk);
    rst = 1'b1;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check_output("rst_mem_addr", mem_addr, 32'h0);
    check_output("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check_output("rst_mem_wdata", mem_wdata, 32'h0);
    check_output("rst_x1_cleared", dut.registers[1], 32'h0);
    we_base = we_count;
    rst = 1'b0;
  endtask

  // Instruction-level reference interpreter for the random programs.
  task automatic iss_run();
    logic [31:0] pc, ins, a, b, op2, imm_i, imm_s, res, addr, w;
    logic [4:0]  sh;
    bit          wr;
    pc = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    for (int step = 0; step < 200; step++) begin
      ins = mm[pc[9:2]];
      if (ins == LOOP) break;
      a     = mregs[ins[19:15]];
      b     = mregs[ins[24:20]];
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      wr    = 1'b1;
      res   = 32'h0;
      case (ins[6:0])
        7'h37: res = {ins[31:12], 12'h0};
        7'h17: res = pc + {ins[31:12], 12'h0};
        7'h13, 7'h33: begin
          op2 = (ins[6:0] == 7'h13) ? imm_i : b;
          sh  = op2[4:0];
          case (ins[14:12])
            3'd0: res = (ins[6:0] == 7'h33 && ins[30]) ? a - op2 : a + op2;
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
            3'd3: res = (a < op2) ? 32'd1 : 32'd0;
            3'd4: res = a ^ op2;
            3'd5: begin
              if (ins[30]) res = $unsigned($signed(a) >>> sh);
              else         res = a >> sh;
            end
            3'd6: res = a | op2;
            default: res = a & op2;
          endcase
        end
        7'h03: begin
          addr = a + imm_i;
          w = mm[addr[9:2]] >> (8 * addr[1:0]);
          case (ins[14:12])
            3'd0: res = {{24{w[7]}}, w[7:0]};
            3'd1: res = {{16{w[15]}}, w[15:0]};
            3'd4: res = {24'h0, w[7:0]};
            3'd5: res = {16'h0, w[15:0]};
            default: res = mm[addr[9:2]];
          endcase
        end
        default: begin
          addr = a + imm_s;
          mm[addr[9:2]] = b;
          wr = 1'b0;
        end
      endcase
      if (wr && ins[11:7] != 5'd0) mregs[ins[11:7]] = res;
      pc = pc + 32'd4;
    end
  endtask

  task automatic gen_random_program();
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [4:0]  rd, rs1, rs2;
    int          kind, lane;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 5);
      rd   = 5'($urandom_range(0, 7));
      rs1  = 5'($urandom_range(0, 7));
      rs2  = 5'($urandom_range(0, 7));
      f3   = 3'($urandom_range(0, 7));
      case (kind)
        0: img[k] = enc_r((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00,
                          rs2, rs1, f3, rd);
        1: begin
          imm = 12'($urandom);
          if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
          if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
          img[k] = enc_i(imm, rs1, f3, rd, 7'h13);
        end
        2: img[k] = {20'($urandom), rd, 7'h37};
        3: img[k] = {20'($urandom), rd, 7'h17};
        4: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
          if (f3 == 3'd2) lane = 0;
          else if (f3 == 3'd1 || f3 == 3'd5) lane = 2 * $urandom_range(0, 1);
          else lane = $urandom_range(0, 3);
          imm = 12'(12'h200 + 4 * $urandom_range(0, 63) + lane);
          img[k] = enc_i(imm, 5'd0, f3, rd, 7'h03);
        end
        default: img[k] = enc_s(12'(12'h200 + 4 * $urandom_range(0, 63)), rs2, 5'd0);
      endcase
    end
    img[24] = LOOP;
    for (int i = 128; i < 192; i++) img[i] = $urandom;
  endtask

  initial begin
    // Basic ALU program
    clear_img();
    img[0] = 32'h00400093;
    img[1] = 32'h00200113;
    img[2] = 32'h002081b3;
    img[3] = 32'h40208233;
    img[4] = LOOP;
    apply_stimulus();
    check_output("first_fetch_addr", mem_addr, 32'h0);
    repeat (40) @(negedge clk);
    check_output("alu_x1", dut.registers[1], 32'd4);
    check_output("alu_x2", dut.registers[2], 32'd2);
    check_output("alu_x3", dut.registers[3], 32'd6);
    check_output("alu_x4", dut.registers[4], 32'd2);

    // x0 hardwired to zero
    clear_img();
    img[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
    img[1] = enc_i(12'd7, 5'd0, 3'd0, 5'd5, 7'h13);
    img[2] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5);
    img[3] = LOOP;
    apply_stimulus();
    repeat (30) @(negedge clk);
    check_output("x0_zero", dut.registers[0], 32'h0);
    check_output("x5_add_x0", dut.registers[5], 32'h0);

    // Store then loads of every width
    clear_img();
    img[0] = enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13);
    img[1] = enc_i(12'hF80, 5'd0, 3'd0, 5'd2, 7'h13);
    img[2] = enc_s(12'h000, 5'd2, 5'd1);
    img[3] = enc_i(12'h000, 5'd1, 3'd2, 5'd3, 7'h03);
    img[4] = enc_i(12'h000, 5'd1, 3'd0, 5'd4, 7'h03);
    img[5] = enc_i(12'h000, 5'd1, 3'd4, 5'd5, 7'h03);
    img[6] = enc_i(12'h002, 5'd1, 3'd5, 5'd6, 7'h03);
    img[7] = enc_i(12'h001, 5'd1, 3'd0, 5'd7, 7'h03);
    img[8] = enc_i(12'h000, 5'd1, 3'd1, 5'd8, 7'h03);
    img[9] = LOOP;
    apply_stimulus();
    repeat (40) @(negedge clk);
    check_output("sw_mem_word", mem[64], 32'hFFFFFF80);
    check_output("lw_x3", dut.registers[3], 32'hFFFFFF80);
    check_output("lb_x4", dut.registers[4], 32'hFFFFFF80);
    check_output("lbu_x5", dut.registers[5], 32'h00000080);
    check_output("lhu_hi_x6", dut.registers[6], 32'h0000FFFF);
    check_output("lb_byte1_x7", dut.registers[7], 32'hFFFFFFFF);
    check_output("lh_x8", dut.registers[8], 32'hFFFFFF80);
    check_output("mem_we_cycles", 32'(we_count - we_base), 32'd1);

    // Branches: x1=-1, x2=1
    clear_img();
    img[0]  = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13);
    img[1]  = enc_i(12'h001, 5'd0, 3'd0, 5'd2, 7'h13);
    img[2]  = enc_b(13'd8, 5'd2, 5'd1, 3'd4);
    img[3]  = enc_i(12'd1, 5'd0, 3'd0, 5'd3, 7'h13);
    img[4]  = enc_b(13'd8, 5'd2, 5'd1, 3'd6);
    img[5]  = enc_i(12'd2, 5'd0, 3'd0, 5'd4, 7'h13);
    img[6]  = enc_b(13'd8, 5'd2, 5'd1, 3'd5);
    img[7]  = enc_i(12'd6, 5'd0, 3'd0, 5'd6, 7'h13);
    img[8]  = enc_b(13'd8, 5'd2, 5'd1, 3'd7);
    img[9]  = enc_i(12'd7, 5'd0, 3'd0, 5'd7, 7'h13);
    img[10] = enc_b(13'd8, 5'd2, 5'd1, 3'd1);
    img[11] = enc_i(12'd8, 5'd0, 3'd0, 5'd8, 7'h13);
    img[12] = enc_b(13'd8, 5'd1, 5'd1, 3'd0);
    img[13] = enc_i(12'd9, 5'd0, 3'd0, 5'd9, 7'h13);
    img[14] = enc_i(12'd10, 5'd0, 3'd0, 5'd10, 7'h13);
    img[15] = LOOP;
    apply_stimulus();
    repeat (60) @(negedge clk);
    check_output("blt_taken_skip_x3", dut.registers[3], 32'd0);
    check_output("bltu_not_taken_x4", dut.registers[4], 32'd2);
    check_output("bge_not_taken_x6", dut.registers[6], 32'd6);
    check_output("bgeu_taken_skip_x7", dut.registers[7], 32'd0);
    check_output("bne_taken_skip_x8", dut.registers[8], 32'd0);
    check_output("beq_taken_skip_x9", dut.registers[9], 32'd0);
    check_output("after_branches_x10", dut.registers[10], 32'd10);

    // JAL / JALR (target bit0 cleared)
    clear_img();
    for (int i = 0; i < 4; i++) img[i] = 32'h00000013;
    img[4] = enc_j(21'd8, 5'd1);
    img[5] = enc_i(12'h055, 5'd0, 3'd0, 5'd2, 7'h13);
    img[6] = enc_i(12'h001, 5'd1, 3'd0, 5'd0, 7'h67);
    apply_stimulus();
    repeat (8) @(negedge clk);
    check_output("jal_fetch_pc", mem_addr, 32'h10);
    repeat (2) @(negedge clk);
    check_output("jal_target_fetch", mem_addr, 32'h18);
    check_output("jal_link_x1", dut.registers[1], 32'h14);
    repeat (2) @(negedge clk);
    check_output("jalr_target_fetch", mem_addr, 32'h14);
    repeat (2) @(negedge clk);
    check_output("after_jalr_x2", dut.registers[2], 32'h55);

    // Reset asserted during the MEM cycle of a SW
    clear_img();
    img[0]  = enc_i(12'h100, 5'd0, 3'd0, 5'd1, 7'h13);
    img[1]  = enc_i(12'hF80, 5'd0, 3'd0, 5'd2, 7'h13);
    img[2]  = enc_s(12'h000, 5'd2, 5'd1);
    img[3]  = LOOP;
    img[64] = 32'h12345678;
    apply_stimulus();
    repeat (6) @(negedge clk);
    check_output("sw_mem_cycle_we", {31'b0, mem_we}, 32'd1);
    check_output("sw_mem_cycle_addr", mem_addr, 32'h100);
    rst = 1'b1;
    #1;
    check_output("rst_drops_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check_output("rst_mem_unchanged", mem[64], 32'h12345678);
    check_output("rst_clears_x1", dut.registers[1], 32'h0);
    rst = 1'b0;
    check_output("post_rst_fetch_addr", mem_addr, 32'h0);

    // Randomized ALU/load/store programs against the reference interpreter
    for (int r = 0; r < 5; r++) begin
      clear_img();
      gen_random_program();
      apply_stimulus();
      repeat (110) @(negedge clk);
      iss_run();
      for (int i = 0; i < 32; i++)
        check_output($sformatf("rand%0d_x%0d", r, i), dut.registers[i], mregs[i]);
      for (int i = 128; i < 192; i++)
        check_output($sformatf("rand%0d_mem%0d", r, i), mem[i], mm[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
